// File: rtl/seq_pkg.sv
// Shared state encoding and frame pattern for the 1110 generator and its detectors.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S0   = 3'd4,
    ST_GAP  = 3'd5
  } state_e;

  localparam logic [3:0] PAT_1110 = 4'b1110;

  // Frame bit presented in each frame state, MSB of the pattern first.
  function automatic logic pat_bit(state_e st);
    logic b;
    b = 1'b0;
    case (st)
      ST_S1:   b = PAT_1110[3];
      ST_S2:   b = PAT_1110[2];
      ST_S3:   b = PAT_1110[1];
      ST_S0:   b = PAT_1110[0];
      default: b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seq_frame_ctr.sv
// Remaining-frame counter: load, saturating decrement, clear, and zero/last flags.
module seq_frame_ctr #(
  parameter int unsigned NFR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [NFR_W-1:0] load_val,
  output logic             zero,
  output logic             last
);

  logic [NFR_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - NFR_W'(1);
    end
  end

  assign zero = (cnt_q == '0);
  assign last = (cnt_q == NFR_W'(1));

endmodule

// File: rtl/seq_gen_1110.sv
// Serial "1110" frame generator (Moore FSM). Define SEQ_GEN_GAP_EN to insert one
// idle GAP cycle between consecutive frames.
module seq_gen_1110
  import seq_pkg::*;
#(
  parameter int unsigned NFR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NFR_W-1:0] nframes,
  input  logic             abort,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_e state_q, state_d;
  logic   done_q, done_d;
  logic   ctr_clr, ctr_load, ctr_dec;
  logic   ctr_zero, ctr_last;

  seq_frame_ctr #(
    .NFR_W(NFR_W)
  ) u_frame_ctr (
    .clk      (clk),
    .rst      (rst),
    .clr      (ctr_clr),
    .load     (ctr_load),
    .dec      (ctr_dec),
    .load_val (nframes),
    .zero     (ctr_zero),
    .last     (ctr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    ctr_clr  = 1'b0;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    if (abort) begin
      // Abort wins over everything, including a same-cycle start.
      state_d = ST_IDLE;
      ctr_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (nframes != '0) begin
              state_d  = ST_S1;
              ctr_load = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_S1: state_d = ST_S2;
        ST_S2: state_d = ST_S3;
        ST_S3: state_d = ST_S0;
        ST_S0: begin
          ctr_dec = 1'b1;
          if (ctr_last || ctr_zero) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
`ifdef SEQ_GEN_GAP_EN
            state_d = ST_GAP;
`else
            state_d = ST_S1;
`endif
          end
        end
`ifdef SEQ_GEN_GAP_EN
        ST_GAP: state_d = ST_S1;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign out   = pat_bit(state_q);
  assign valid = (state_q == ST_S1) || (state_q == ST_S2) ||
                 (state_q == ST_S3) || (state_q == ST_S0);
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_seq_gen_1110.sv
// Scoreboard bench for seq_gen_1110: expected frame bits are queued by the stimulus and
// popped by a negedge monitor whenever valid is high; a 1110 detector runs on the loopback.
module tb_seq_gen_1110;

  localparam int unsigned NfrW = 4;
`ifdef SEQ_GEN_GAP_EN
  localparam int Gap = 1;
`else
  localparam int Gap = 0;
`endif

  logic            clk = 1'b0;
  logic            rst, start, abort;
  logic [NfrW-1:0] nframes;
  logic            out, valid, busy, done;

  int       n_cmp = 0;
  int       n_err = 0;
  bit       exp_q[$];
  int       frames_exp = 0;
  int       done_exp = 0;
  int       done_seen = 0;
  int       det_cnt = 0;
  logic [3:0] det_sh = 4'b0000;
  bit       mon_en = 1'b0;

  always #5 clk = ~clk;

  seq_gen_1110 #(
    .NFR_W(NfrW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .nframes (nframes),
    .abort   (abort),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop, done counting and non-overlapping 1110 detector.
  always @(negedge clk) begin : mon
    bit e;
    if (mon_en) begin
      if (done === 1'b1) done_seen++;
      if (valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame_bit", 32'(out), 32'd2);
        end else begin
          e = exp_q.pop_front();
          check("serial_bit", 32'(out), 32'(e));
        end
        det_sh = {det_sh[2:0], out};
        if (det_sh == 4'b1110) begin
          det_cnt++;
          det_sh = 4'b0000;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input int n_frames);
    for (int i = 0; i < n_frames; i++) begin
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
    end
  endtask

  // Start a transfer of n frames and wait (bounded) for done; poke keeps start high
  // with a different nframes for the first cycles of the transfer.
  task automatic run(input int n, input bit poke, input string name);
    int cyc;
    int lat;
    cyc = 0;
    lat = (n == 0) ? 0 : 4 * n + Gap * (n - 1);
    push_bits(n);
    frames_exp += n;
    start   = 1'b1;
    nframes = n[NfrW-1:0];
    tick();
    nframes = ~nframes;
    if (!poke) start = 1'b0;
    check({name, "_busy_after_start"}, 32'(busy), 32'(n != 0));
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
      if (cyc == 3) start = 1'b0;
    end
    start = 1'b0;
    check({name, "_done_latency"}, 32'(cyc), 32'(lat));
    check({name, "_idle_at_done"}, 32'(busy), 32'd0);
    done_exp++;
  endtask

  initial begin : stim
    int snap;
    rst     = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    nframes = '0;
    tick();
    tick();
    check("reset_outputs", 32'({out, valid, busy, done}), 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;
    tick();

    run(1, 1'b0, "single");
    // Starts in the cycle done is high.
    run(3, 1'b0, "three");
    tick();

    // Abort in S2 of frame 2 of 4.
    push_bits(1);
    frames_exp += 1;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    start   = 1'b1;
    nframes = 4'd4;
    tick();
    start = 1'b0;
    repeat (5 + Gap) tick();
    check("abort_in_s2_out", 32'(out), 32'd1);
    abort = 1'b1;
    snap  = done_seen;
    tick();
    abort = 1'b0;
    check("abort_outputs", 32'({out, valid, busy, done}), 32'd0);
    repeat (4) tick();
    check("abort_no_done", 32'(done_seen), 32'(snap));
    run(1, 1'b0, "after_abort");
    tick();

    run(0, 1'b0, "zero");
    tick();
    check("zero_done_one_cycle", 32'(done), 32'd0);
    run(15, 1'b0, "fifteen");
    tick();
    run(2, 1'b1, "start_while_busy");
    tick();

    // Abort and start together in IDLE.
    start   = 1'b1;
    abort   = 1'b1;
    nframes = 4'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start_busy", 32'(busy), 32'd0);
    tick();
    check("abort_beats_start_done", 32'(done), 32'd0);

    // Reset mid-frame while in S3.
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    start   = 1'b1;
    nframes = 4'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
    start = 1'b1;
    snap = done_seen;
    tick();
    start = 1'b0;
    check("midframe_reset_outputs", 32'({out, valid, busy, done}), 32'd0);
    rst = 1'b1;
    repeat (6) tick();
    check("midframe_reset_no_done", 32'(done_seen), 32'(snap));
    run(1, 1'b0, "post_reset");
    repeat (3) tick();

    mon_en = 1'b0;
    check("bits_left_in_queue", 32'(exp_q.size()), 32'd0);
    check("done_pulse_count", 32'(done_seen), 32'(done_exp));
    check("loopback_detections", 32'(det_cnt), 32'(frames_exp));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
